// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ImmSrc encodings, encoder FSM states and
// the immediate range check used when RV_ENC_CHECK_EN is defined.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Same encodings as the main decoder's ImmSrc; 101..111 are reserved.
   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // True when the immediate is representable in the selected format.
   function automatic logic imm_ok(input logic [2:0] src, input logic [31:0] imm,
                                   input logic is_r);
      logic ok;
      case (src)
         IMM_U:   ok = 1'b1;
         IMM_B:   ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
         IMM_J:   ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
         default: ok = (&imm[31:11]) | ~(|imm[31:11]);
      endcase
      return is_r | ok;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-side bundle of the instruction encoder: run control, field bundle,
// imem write port and status. master = loader, slave = encoder.
interface instr_encoder_if #(
   parameter int AW = 32,
   parameter int CW = 16
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] n_instr;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    op;
   logic [2:0]    funct3;
   logic          funct7b5;
   logic [4:0]    rd;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [31:0]   imm;
   logic [2:0]    imm_src;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, base_addr, n_instr, in_valid, op, funct3, funct7b5,
             rd, rs1, rs2, imm, imm_src,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
   );

   modport slave (
      input  start, base_addr, n_instr, in_valid, op, funct3, funct7b5,
             rd, rs1, rs2, imm, imm_src,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
   );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field placer: builds instruction bits [31:7] from the
// immediate, register indices and format select. Opcode is appended by the caller.
module imm_pack
   import rv32i_pkg::*;
(
   input  logic [2:0]  imm_src,
   input  logic [31:0] imm,
   input  logic        f7b5,
   input  logic        is_r,
   input  logic        is_shift,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   output logic [6:0]  f31_25,
   output logic [4:0]  f24_20,
   output logic [7:0]  f19_12,
   output logic [4:0]  f11_7
);

   always_comb begin
      // NOTE: every output gets an I-format default before the case, so no
      // path leaves a field unassigned and no latch is inferred.
      f31_25 = imm[11:5];
      f24_20 = imm[4:0];
      f19_12 = {rs1, funct3};
      f11_7  = rd;

      if (is_r) begin
         f31_25 = {1'b0, f7b5, 5'b00000};
         f24_20 = rs2;
      end else begin
         case (imm_src)
            IMM_S: begin
               f24_20 = rs2;
               f11_7  = imm[4:0];
            end
            IMM_B: begin
               f31_25 = {imm[12], imm[10:5]};
               f24_20 = rs2;
               f11_7  = {imm[4:1], imm[11]};
            end
            IMM_U: begin
               f31_25 = imm[31:25];
               f24_20 = imm[24:20];
               f19_12 = imm[19:12];
            end
            IMM_J: begin
               f31_25 = {imm[20], imm[10:5]};
               f24_20 = {imm[4:1], imm[11]};
               f19_12 = imm[19:12];
            end
            default: begin
               // Shift-immediates carry funct7 in the upper immediate bits.
               if (is_shift) f31_25 = {1'b0, f7b5, 5'b00000};
            end
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words into imem, one per accepted bundle, with a
// one-cycle write latency. Optional field checking: define RV_ENC_CHECK_EN.
module instr_encoder
   import rv32i_pkg::*;
#(
   parameter int AW = 32,
   parameter int CW = 16
) (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr;
   logic          accept;
   logic          last;
   logic          fld_ok;
   logic          is_r;
   logic          is_shift;
   logic [6:0]    f31_25;
   logic [4:0]    f24_20;
   logic [7:0]    f19_12;
   logic [4:0]    f11_7;
   logic [31:0]   word;

   assign accept   = bus.in_valid && (state == S_RUN);
   assign last     = (count == CW'(1));
   assign is_r     = (bus.op == OP_R);
   assign is_shift = (bus.op == OP_IMM) && (bus.funct3[1:0] == 2'b01);

   imm_pack u_imm_pack (
      .imm_src  (bus.imm_src),
      .imm      (bus.imm),
      .f7b5     (bus.funct7b5),
      .is_r     (is_r),
      .is_shift (is_shift),
      .rd       (bus.rd),
      .rs1      (bus.rs1),
      .rs2      (bus.rs2),
      .funct3   (bus.funct3),
      .f31_25   (f31_25),
      .f24_20   (f24_20),
      .f19_12   (f19_12),
      .f11_7    (f11_7)
   );

   assign word = {f31_25, f24_20, f19_12, f11_7, bus.op};

`ifdef RV_ENC_CHECK_EN
   assign fld_ok = imm_ok(bus.imm_src, bus.imm, is_r);
`else
   assign fld_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = (bus.n_instr == '0) ? S_DONE : S_RUN;
         S_RUN:   if (accept && last) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.in_ready = (state == S_RUN);
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         count         <= '0;
         wr_ptr        <= '0;
      end else begin
         bus.mem_we <= accept && fld_ok;
         if (state == S_IDLE && bus.start) begin
            count  <= bus.n_instr;
            wr_ptr <= bus.base_addr & ~AW'(3);
         end
         // Rejected bundles still consume a count but leave the address alone.
         if (accept) begin
            count <= count - CW'(1);
            if (fld_ok) begin
               bus.mem_addr  <= wr_ptr;
               bus.mem_wdata <= word;
               wr_ptr        <= wr_ptr + AW'(4);
            end
         end
      end
   end

`ifdef RV_ENC_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)                              bus.err <= 1'b0;
      else if (state == S_IDLE && bus.start)  bus.err <= 1'b0;
      else if (accept && !fld_ok)             bus.err <= 1'b1;
   end
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; honours RV_ENC_CHECK_EN
// when the design is built with it.
module tb_instr_encoder;
   import rv32i_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_encoder_if bus ();

   instr_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [2:0]  src;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[5];

   // Write/done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wq_addr.push_back(bus.mem_addr);
         wq_data.push_back(bus.mem_wdata);
      end
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
      done_cnt = 0;
   endtask

   task automatic start_run(input logic [31:0] base, input logic [15:0] n);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.n_instr   = n;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Presents one bundle for one cycle; returns 1 time unit after the accepting edge.
   task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [2:0] src);
      @(negedge clk);
      bus.op       = op;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.rd       = rd;
      bus.rs1      = rs1;
      bus.rs2      = rs2;
      bus.imm      = imm;
      bus.imm_src  = src;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check({tag, "_idle_timeout"}, 32'(n >= 100), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"sw",   OP_STORE,  3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         3'b001, 32'h0020A423};
      vecs[1] = '{"beq",  OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         3'b010, 32'h00208463};
      vecs[2] = '{"jal",  OP_JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16,        3'b011, 32'h010000EF};
      vecs[3] = '{"lui",  OP_LUI,    3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,  3'b100, 32'h123452B7};
      vecs[4] = '{"srai", OP_IMM,    3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,         3'b000, 32'h40315093};

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.n_instr   = '0;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.funct3    = '0;
      bus.funct7b5  = 1'b0;
      bus.rd        = '0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.imm       = '0;
      bus.imm_src   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  bus.busy,      0);
      check("rst_we",    bus.mem_we,    0);
      check("rst_done",  bus.done,      0);
      check("rst_err",   bus.err,       0);
      check("rst_addr",  bus.mem_addr,  0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_ready", bus.in_ready,  0);
      @(negedge clk);
      reset = 1'b0;

      // addi x1,x0,5 with exact latency checks
      start_run(32'h100, 16'd1);
      check("run_busy",  bus.busy,     1);
      check("run_ready", bus.in_ready, 1);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      check("addi_we",    bus.mem_we,    1);
      check("addi_addr",  bus.mem_addr,  32'h100);
      check("addi_wdata", bus.mem_wdata, 32'h00500093);
      check("addi_done",  bus.done,      1);
      @(posedge clk);
      #1;
      check("post_we",   bus.mem_we, 0);
      check("post_done", bus.done,   0);
      check("post_busy", bus.busy,   0);

      // add then sub back-to-back
      clear_q();
      start_run(32'h100, 16'd2);
      push(OP_R, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 3'b000);
      push(OP_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 3'b000);
      wait_idle("addsub");
      check("addsub_n",      wq_data.size(), 2);
      check("add_wdata",     wq_data[0], 32'h002081B3);
      check("add_addr",      wq_addr[0], 32'h100);
      check("sub_wdata",     wq_data[1], 32'h402081B3);
      check("sub_addr",      wq_addr[1], 32'h104);
      check("addsub_done_n", done_cnt,   1);

      // remaining formats from a table
      clear_q();
      start_run(32'h200, 16'd5);
      for (int i = 0; i < 5; i++)
         push(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
              vecs[i].imm, vecs[i].src);
      wait_idle("fmt");
      check("fmt_n", wq_data.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check({vecs[i].name, "_wdata"}, wq_data[i], vecs[i].exp);
         check({vecs[i].name, "_addr"},  wq_addr[i], 32'h200 + 32'(4 * i));
      end

      // in_valid gaps
      clear_q();
      start_run(32'h400, 16'd3);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      repeat (2) @(negedge clk);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      @(negedge clk);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      wait_idle("gap");
      check("gap_n",      wq_data.size(), 3);
      check("gap_done_n", done_cnt,       1);
      check("gap_addr2",  wq_addr[2],     32'h408);

      // address wrap, low base bits forced to zero
      clear_q();
      start_run(32'hFFFF_FFFE, 16'd2);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      wait_idle("wrap");
      check("wrap_n",     wq_data.size(), 2);
      check("wrap_addr0", wq_addr[0],     32'hFFFF_FFFC);
      check("wrap_addr1", wq_addr[1],     32'h0);

      // zero-length run
      clear_q();
      start_run(32'h100, 16'd0);
      check("zero_done", bus.done,   1);
      check("zero_we",   bus.mem_we, 0);
      @(posedge clk);
      #1;
      check("zero_done_off", bus.done, 0);
      check("zero_busy_off", bus.busy, 0);
      check("zero_writes",   wq_data.size(), 0);

      // reset mid-run
      clear_q();
      start_run(32'h300, 16'd4);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_we",    bus.mem_we,   0);
      check("mrst_busy",  bus.busy,     0);
      check("mrst_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("mrst_writes", wq_data.size(), 1);

      // misaligned branch offset
      clear_q();
      start_run(32'h500, 16'd2);
      push(OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 3'b010);
`ifdef RV_ENC_CHECK_EN
      check("chk_we",  bus.mem_we, 0);
      check("chk_err", bus.err,    1);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      check("chk_next_addr", bus.mem_addr, 32'h500);
      check("chk_err_hold",  bus.err,      1);
      wait_idle("chk");
      check("chk_done_n", done_cnt, 1);
      start_run(32'h600, 16'd0);
      check("chk_err_clr", bus.err, 0);
`else
      check("nochk_we",    bus.mem_we,    1);
      check("nochk_wdata", bus.mem_wdata, 32'h00208163);
      check("nochk_err",   bus.err,       0);
      push(OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000);
      check("nochk_addr",  bus.mem_addr,  32'h504);
      wait_idle("nochk");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
